alu_nibble_sequencer: RTL and testbench

Multi-cycle arithmetic controller that runs one shared 4-bit Brent-Kung adder nibble-serially to perform ADD/SUB/ADC/SBC on 4·NIBBLES-bit operands. It owns the request/response handshake, operand registers, the carry register between nibbles, and the final flag computation. It sits between the ALU front-end (issuer) and the 4-bit Brent-Kung adder built from the gray/black prefix cells.

---
 rtl/alu_nibble_sequencer_pkg.sv | 32 +++
 rtl/alu_nibble_sequencer_bk_adder4.sv | 51 +++++
 rtl/alu_nibble_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: slice width, opcode
// encodings, FSM state encodings and small opcode-decode helpers.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Subtractions add the one's complement of b.
  function automatic logic op_inverts_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Carry into nibble 0: fixed for ADD/SUB, taken from cin for ADC/SBC.
  function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_bk_adder4.sv
// 4-bit Brent-Kung adder built from gray/black prefix cells; the carry-in is
// folded into bit 0's generate so the whole tree sees a single prefix chain.
module gray_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  output logic g_out
);
  assign g_out = g_hi | (p_hi & g_lo);
endmodule

module black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

module bk_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_g32;
  logic       w_p32;

  assign w_g = a & b;
  assign w_p = a ^ b;

  gray_cell  u_c1  (.g_hi(w_g[0]), .p_hi(w_p[0]), .g_lo(ci),   .g_out(w_c1));
  gray_cell  u_c2  (.g_hi(w_g[1]), .p_hi(w_p[1]), .g_lo(w_c1), .g_out(w_c2));
  black_cell u_g32 (.g_hi(w_g[3]), .p_hi(w_p[3]), .g_lo(w_g[2]), .p_lo(w_p[2]),
                    .g_out(w_g32), .p_out(w_p32));
  gray_cell  u_co  (.g_hi(w_g32),  .p_hi(w_p32),  .g_lo(w_c2), .g_out(co));
  // Reverse-tree cell fills in the odd-position carry.
  gray_cell  u_c3  (.g_hi(w_g[2]), .p_hi(w_p[2]), .g_lo(w_c2), .g_out(w_c3));

  assign s = w_p ^ {w_c3, w_c2, w_c1, ci};
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ADD/SUB/ADC/SBC controller: one shared 4-bit adder is stepped
// across the operand, low nibble first, with a carry register between slices.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                op,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                      cout,
  output logic                      zero,
  output logic                      ovf,
  output logic [1:0]                o_dbg_state
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; both ready/valid
  // outputs decode from state alone and never depend on the partner's signal.

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_carry;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_co;
  logic [W-1:0]        w_result_next;
  logic [W-1:0]        w_b_eff;
  logic                w_last;

  assign w_b_eff = op_inverts_b(op) ? ~b : b;
  assign w_last  = (r_idx == LAST_IDX);

  always_comb begin
    w_a_nib       = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    w_b_nib       = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    w_result_next = r_result;
    w_result_next[int'(r_idx)*NIBBLE_W +: NIBBLE_W] = w_sum;
  end

  bk_adder4 u_adder (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= op_carry_in(op, cin);
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result <= w_result_next;
          r_carry  <= w_co;
          r_idx    <= r_idx + IDX_W'(1);
          if (w_last) begin
            // Flags are taken from the fully assembled word on the final slice.
            r_idx   <= '0;
            r_cout  <= w_co;
            r_zero  <= ~|w_result_next;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_result_next[W-1] != r_a[W-1]);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign cout        = r_cout;
  assign zero        = r_zero;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed and random checks of the nibble-serial ALU sequencer with a
// scoreboard queue of {cout, zero, ovf, result} expectations.
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         rsp_ready = 1'b0;
  logic         cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [W+2:0] exp_q[$];

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .cin(cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .result(result), .cout(cout), .zero(zero),
    .ovf(ovf), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, independent of the slice order.
  function automatic logic [W+2:0] model(input logic [1:0] m_op, input logic [W-1:0] m_a,
                                         input logic [W-1:0] m_b, input logic m_cin);
    logic [W-1:0] beff;
    logic [W:0]   sum;
    logic         c;
    logic         o;
    beff = (m_op == OP_SUB || m_op == OP_SBC) ? ~m_b : m_b;
    c    = (m_op == OP_ADD) ? 1'b0 : (m_op == OP_SUB) ? 1'b1 : m_cin;
    sum  = {1'b0, m_a} + {1'b0, beff} + {{W{1'b0}}, c};
    o    = (m_a[W-1] == beff[W-1]) && (sum[W-1] != m_a[W-1]);
    return {sum[W], (sum[W-1:0] == '0), o, sum[W-1:0]};
  endfunction

  // driver: waits (bounded) for req_ready, then transfers one request
  task automatic issue(input logic [1:0] i_op, input logic [W-1:0] i_a,
                       input logic [W-1:0] i_b, input logic i_cin, input logic [W+2:0] exp);
    int t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("issue_ready", {31'd0, req_ready}, 32'd1);
    op = i_op; a = i_a; b = i_b; cin = i_cin; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom); cin = 1'($urandom);
    exp_q.push_back(exp);
  endtask

  // collector: checks latency, optionally stalls in DONE, then drains
  task automatic collect(input string tag, input int hold);
    int n = 0;
    logic [W+2:0] e;
    while (!rsp_valid && n < 3 * NIBBLES) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NIBBLES));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_result"}, 32'({cout, zero, ovf, result}), 32'(e));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, "_hold_out"}, 32'({cout, zero, ovf, result}), 32'(e));
      check({tag, "_hold_rdy"}, {30'd0, req_ready, rsp_valid}, 32'b01);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, req_ready, rsp_valid}, 32'b10);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_cin;

    // reset state
    #12;
    check("rst_outputs", 32'({cout, zero, ovf, result}), 32'd0);
    check("rst_hs", {30'd0, req_ready, rsp_valid}, 32'b10);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 16'h1234, 16'h0FFF, 1'b0, {1'b0, 1'b0, 1'b0, 16'h2233}); collect("add_basic", 0);
    issue(OP_SUB, 16'h0005, 16'h0007, 1'b0, {1'b0, 1'b0, 1'b0, 16'hFFFE}); collect("sub_neg", 0);
    issue(OP_SUB, 16'h0007, 16'h0007, 1'b0, {1'b1, 1'b1, 1'b0, 16'h0000}); collect("sub_zero", 0);
    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b0, 1'b1, 16'h8000}); collect("add_ovf", 0);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b1, 1'b0, 16'h0000}); collect("add_wrap", 0);
    issue(OP_ADC, 16'h00FF, 16'h0000, 1'b1, {1'b0, 1'b0, 1'b0, 16'h0100}); collect("adc_cin", 0);
    issue(OP_SBC, 16'h0100, 16'h0000, 1'b0, {1'b1, 1'b0, 1'b0, 16'h00FF}); collect("sbc_borrow", 0);

    // backpressure in DONE with noisy request side
    issue(OP_ADD, 16'h1111, 16'h2222, 1'b0, {1'b0, 1'b0, 1'b0, 16'h3333}); collect("bp", 5);
    check("bp_no_accept", 32'(dbg_state), 32'(ST_IDLE));

    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3)); r_a = W'($urandom); r_b = W'($urandom);
      r_cin = 1'($urandom_range(0, 1));
      issue(r_op, r_a, r_b, r_cin, model(r_op, r_a, r_b, r_cin)); collect("rand", 0);
    end

    // asynchronous reset during the second RUN cycle
    issue(OP_ADD, 16'hAAAA, 16'h1111, 1'b0, model(OP_ADD, 16'hAAAA, 16'h1111, 1'b0));
    void'(exp_q.pop_back());
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out", 32'({cout, zero, ovf, result}), 32'd0);
    check("midrun_rst_hs", {30'd0, req_ready, rsp_valid}, 32'b10);
    check("midrun_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
    issue(OP_ADD, 16'h4321, 16'h1234, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555}); collect("post_rst_add", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
